// File: rtl/bonus_hole_ctrl.sv
// Bonus pocket controller: picks a random free pocket as the bonus target,
// awards points when the current shooter pockets it, and re-targets after a
// hit or a frame timeout until every pocket of the round has been cleared.
module bonus_hole_ctrl #(
   parameter int NUM_HOLES      = 6,
   parameter int TIMEOUT_FRAMES = 300,
   parameter int BONUS_POINTS   = 5,
   parameter int RAND_LATENCY   = 2
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 startOfFrame,
   input  logic                 new_round,
   input  logic [2:0]           rand_hole,
   output logic                 rand_rise,
   input  logic                 ball_in_hole,
   input  logic [2:0]           ball_hole,
   input  logic                 player,
   output logic [2:0]           target_hole,
   output logic                 target_valid,
   output logic [NUM_HOLES-1:0] hole_mask,
   output logic                 bonus_hit,
   output logic [7:0]           score_p0,
   output logic [7:0]           score_p1,
   output logic [8:0]           frames_left
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      REQUEST   = 3'd1,
      WAIT_RAND = 3'd2,
      PROBE     = 3'd3,
      ACTIVE    = 3'd4,
      EXHAUSTED = 3'd5
   } state_t;

   localparam logic [2:0] HOLES_CNT  = 3'(NUM_HOLES);
   localparam logic [2:0] LAST_HOLE  = 3'(NUM_HOLES - 1);
   localparam logic [8:0] TIMEOUT_LD = 9'(TIMEOUT_FRAMES);
   localparam logic [8:0] POINTS     = 9'(BONUS_POINTS);
   localparam logic [3:0] LAT_LAST   = 4'(RAND_LATENCY - 1);

   state_t     state;
   logic [2:0] cand;       // pocket currently being probed
   logic [2:0] probe_cnt;  // masked probes seen for this candidate search
   logic [3:0] lat_cnt;    // cycles spent waiting for the random source
   logic       target_hit;

   // Adds the bonus to a score, clamping at the 8-bit maximum.
   function automatic logic [7:0] sat_add(input logic [7:0] score);
      logic [8:0] sum;
      sum = {1'b0, score} + POINTS;
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

   // A pocketing event counts only on the live target and a legal pocket index.
   assign target_hit = ball_in_hole && (ball_hole == target_hole) && (ball_hole < HOLES_CNT);

   // Controller state machine; every output is a register updated here.
   // NOTE: all state is assigned with <= so every register sees the values from
   // before the clock edge, regardless of statement order in this block.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= IDLE;
         target_hole  <= '0;
         target_valid <= 1'b0;
         hole_mask    <= '0;
         bonus_hit    <= 1'b0;
         rand_rise    <= 1'b0;
         score_p0     <= '0;
         score_p1     <= '0;
         frames_left  <= '0;
         cand         <= '0;
         probe_cnt    <= '0;
         lat_cnt      <= '0;
      end else begin
         // Pulses default low; rand_rise is raised only on entry to REQUEST.
         bonus_hit <= 1'b0;
         rand_rise <= 1'b0;
         if (new_round) begin
            hole_mask    <= '0;
            target_valid <= 1'b0;
            rand_rise    <= 1'b1;
            state        <= REQUEST;
         end else begin
            case (state)
               IDLE: begin
                  // Hold everything until a new round starts.
               end
               REQUEST: begin
                  lat_cnt <= '0;
                  state   <= WAIT_RAND;
               end
               WAIT_RAND: begin
                  if (lat_cnt == LAT_LAST) begin
                     cand      <= rand_hole;
                     probe_cnt <= '0;
                     state     <= PROBE;
                  end else begin
                     lat_cnt <= lat_cnt + 4'd1;
                  end
               end
               PROBE: begin
                  if (cand >= HOLES_CNT) begin
                     // Fold an out-of-range random index back into range.
                     cand <= cand - HOLES_CNT;
                  end else if (hole_mask[cand]) begin
                     if (probe_cnt == LAST_HOLE) begin
                        state <= EXHAUSTED;
                     end else begin
                        probe_cnt <= probe_cnt + 3'd1;
                        cand      <= (cand == LAST_HOLE) ? 3'd0 : cand + 3'd1;
                     end
                  end else begin
                     target_hole  <= cand;
                     target_valid <= 1'b1;
                     frames_left  <= TIMEOUT_LD;
                     state        <= ACTIVE;
                  end
               end
               ACTIVE: begin
                  // A hit takes priority over a simultaneous timeout.
                  if (target_hit) begin
                     bonus_hit <= 1'b1;
                     if (player) score_p1 <= sat_add(score_p1);
                     else        score_p0 <= sat_add(score_p0);
                     hole_mask[target_hole] <= 1'b1;
                     target_valid <= 1'b0;
                     rand_rise    <= 1'b1;
                     state        <= REQUEST;
                  end else if (startOfFrame) begin
                     if (frames_left <= 9'd1) begin
                        frames_left  <= '0;
                        target_valid <= 1'b0;
                        rand_rise    <= 1'b1;
                        state        <= REQUEST;
                     end else begin
                        frames_left <= frames_left - 9'd1;
                     end
                  end
               end
               EXHAUSTED: begin
                  target_valid <= 1'b0;
               end
               default: begin
                  target_valid <= 1'b0;
                  state        <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bonus_hole_ctrl.sv
// Directed self-checking bench for bonus_hole_ctrl.
module tb_bonus_hole_ctrl;

   logic       clk = 1'b0;
   logic       resetN;
   logic       startOfFrame;
   logic       new_round;
   logic [2:0] rand_hole;
   logic       rand_rise;
   logic       ball_in_hole;
   logic [2:0] ball_hole;
   logic       player;
   logic [2:0] target_hole;
   logic       target_valid;
   logic [5:0] hole_mask;
   logic       bonus_hit;
   logic [7:0] score_p0;
   logic [7:0] score_p1;
   logic [8:0] frames_left;

   int errors = 0;
   int checks = 0;
   int rise_cnt = 0;
   int hit_cnt = 0;
   int sc0 = 0;
   int sc1 = 0;

   bonus_hole_ctrl dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .new_round    (new_round),
      .rand_hole    (rand_hole),
      .rand_rise    (rand_rise),
      .ball_in_hole (ball_in_hole),
      .ball_hole    (ball_hole),
      .player       (player),
      .target_hole  (target_hole),
      .target_valid (target_valid),
      .hole_mask    (hole_mask),
      .bonus_hit    (bonus_hit),
      .score_p0     (score_p0),
      .score_p1     (score_p1),
      .frames_left  (frames_left)
   );

   always #5 clk = ~clk;

   // Count high cycles of the two pulse outputs.
   always @(posedge clk) begin
      if (rand_rise === 1'b1) rise_cnt++;
      if (bonus_hit === 1'b1) hit_cnt++;
   end

   task automatic new_round_pulse(input logic [2:0] h);
      rand_hole = h;
      new_round = 1'b1;
      @(negedge clk);
      new_round = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (target_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (target_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s wait_valid: target_valid=%b after %0d cycles, required 1", tag, target_valid, n);
      end
   endtask

   task automatic do_hit(input logic [2:0] h, input logic p, input logic [2:0] nxt);
      ball_in_hole = 1'b1;
      ball_hole    = h;
      player       = p;
      rand_hole    = nxt;
      @(negedge clk);
      ball_in_hole = 1'b0;
   endtask

   task automatic frame_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         startOfFrame = 1'b1;
         @(negedge clk);
      end
      startOfFrame = 1'b0;
   endtask

   task automatic test_reset;
      resetN = 1'b0; startOfFrame = 1'b0; new_round = 1'b0; rand_hole = 3'd0;
      ball_in_hole = 1'b0; ball_hole = 3'd0; player = 1'b0;
      #1;
      checks++;
      if ({target_hole, target_valid, hole_mask, bonus_hit, rand_rise} !== 12'd0) begin
         errors++;
         $display("FAIL reset_ctrl: th=%0d tv=%b mask=%b hit=%b rr=%b, required all 0", target_hole, target_valid, hole_mask, bonus_hit, rand_rise);
      end
      checks++;
      if ({score_p0, score_p1, frames_left} !== 25'd0) begin
         errors++;
         $display("FAIL reset_cnt: p0=%0d p1=%0d fl=%0d, required 0", score_p0, score_p1, frames_left);
      end
      @(negedge clk);
      resetN = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (rand_rise !== 1'b0 || target_valid !== 1'b0 || rise_cnt != 0) begin
         errors++;
         $display("FAIL idle_hold: rr=%b tv=%b rises=%0d, required 0 0 0", rand_rise, target_valid, rise_cnt);
      end
   endtask

   task automatic test_basic_target;
      new_round_pulse(3'd3);
      checks++;
      if (rand_rise !== 1'b1) begin
         errors++;
         $display("FAIL basic_rr: rand_rise=%b, required 1", rand_rise);
      end
      wait_valid("basic");
      checks++;
      if (target_hole !== 3'd3 || frames_left !== 9'd300) begin
         errors++;
         $display("FAIL basic_target: th=%0d fl=%0d, required 3 300", target_hole, frames_left);
      end
      checks++;
      if (rise_cnt != 1 || hole_mask !== 6'b000000) begin
         errors++;
         $display("FAIL basic_rise: rises=%0d mask=%b, required 1 000000", rise_cnt, hole_mask);
      end
   endtask

   task automatic test_hit_scoring;
      int h0;
      h0 = hit_cnt;
      do_hit(3'd3, 1'b1, 3'd3);
      sc1 = 5;
      checks++;
      if (bonus_hit !== 1'b1 || score_p1 !== 8'd5 || score_p0 !== 8'd0) begin
         errors++;
         $display("FAIL hit_score: hit=%b p1=%0d p0=%0d, required 1 5 0", bonus_hit, score_p1, score_p0);
      end
      checks++;
      if (hole_mask !== 6'b001000 || target_valid !== 1'b0 || rand_rise !== 1'b1 || target_hole !== 3'd3) begin
         errors++;
         $display("FAIL hit_state: mask=%b tv=%b rr=%b th=%0d, required 001000 0 1 3", hole_mask, target_valid, rand_rise, target_hole);
      end
      @(negedge clk);
      checks++;
      if (bonus_hit !== 1'b0 || hit_cnt != h0 + 1) begin
         errors++;
         $display("FAIL hit_pulse: hit=%b pulses=%0d, required 0 %0d", bonus_hit, hit_cnt - h0, 1);
      end
      wait_valid("retarget");
      checks++;
      if (target_hole !== 3'd4) begin
         errors++;
         $display("FAIL retarget: th=%0d, required 4", target_hole);
      end
   endtask

   task automatic test_non_target;
      int h0;
      h0 = hit_cnt;
      ball_in_hole = 1'b1; ball_hole = 3'd2; player = 1'b1;
      @(negedge clk);
      ball_hole = 3'd7;
      @(negedge clk);
      ball_in_hole = 1'b0;
      @(negedge clk);
      checks++;
      if (score_p1 !== 8'd5 || hit_cnt != h0 || bonus_hit !== 1'b0) begin
         errors++;
         $display("FAIL nontarget_score: p1=%0d pulses=%0d, required 5 0", score_p1, hit_cnt - h0);
      end
      checks++;
      if (target_valid !== 1'b1 || target_hole !== 3'd4 || hole_mask !== 6'b001000 || frames_left !== 9'd300) begin
         errors++;
         $display("FAIL nontarget_state: tv=%b th=%0d mask=%b fl=%0d, required 1 4 001000 300", target_valid, target_hole, hole_mask, frames_left);
      end
   endtask

   task automatic test_probe_wrap;
      new_round_pulse(3'd4);
      wait_valid("probe_a");
      do_hit(3'd4, 1'b0, 3'd5);
      wait_valid("probe_b");
      checks++;
      if (target_hole !== 3'd5) begin
         errors++;
         $display("FAIL probe_setup: th=%0d, required 5", target_hole);
      end
      do_hit(3'd5, 1'b0, 3'd7);
      sc0 = 10;
      wait_valid("probe_c");
      checks++;
      if (target_hole !== 3'd1 || hole_mask !== 6'b110000 || score_p0 !== 8'd10) begin
         errors++;
         $display("FAIL probe_fold: th=%0d mask=%b p0=%0d, required 1 110000 10", target_hole, hole_mask, score_p0);
      end
      new_round_pulse(3'd5);
      wait_valid("probe_d");
      do_hit(3'd5, 1'b0, 3'd5);
      sc0 = 15;
      wait_valid("probe_e");
      checks++;
      if (target_hole !== 3'd0 || hole_mask !== 6'b100000) begin
         errors++;
         $display("FAIL probe_wrap: th=%0d mask=%b, required 0 100000", target_hole, hole_mask);
      end
   endtask

   task automatic test_timeout;
      rand_hole = 3'd0;
      frame_ticks(299);
      checks++;
      if (frames_left !== 9'd1 || target_valid !== 1'b1) begin
         errors++;
         $display("FAIL timeout_299: fl=%0d tv=%b, required 1 1", frames_left, target_valid);
      end
      frame_ticks(1);
      checks++;
      if (target_valid !== 1'b0 || frames_left !== 9'd0 || rand_rise !== 1'b1) begin
         errors++;
         $display("FAIL timeout_300: tv=%b fl=%0d rr=%b, required 0 0 1", target_valid, frames_left, rand_rise);
      end
      checks++;
      if (hole_mask !== 6'b100000 || target_hole !== 3'd0 || score_p0 !== 8'd15) begin
         errors++;
         $display("FAIL timeout_keep: mask=%b th=%0d p0=%0d, required 100000 0 15", hole_mask, target_hole, score_p0);
      end
      wait_valid("timeout");
      checks++;
      if (target_hole !== 3'd0 || frames_left !== 9'd300) begin
         errors++;
         $display("FAIL timeout_retarget: th=%0d fl=%0d, required 0 300", target_hole, frames_left);
      end
      // Collision: hit arrives with the final frame tick.
      frame_ticks(299);
      startOfFrame = 1'b1;
      do_hit(3'd0, 1'b0, 3'd0);
      startOfFrame = 1'b0;
      sc0 = 20;
      checks++;
      if (bonus_hit !== 1'b1 || score_p0 !== 8'd20 || hole_mask !== 6'b100001 || target_valid !== 1'b0) begin
         errors++;
         $display("FAIL collision: hit=%b p0=%0d mask=%b tv=%b, required 1 20 100001 0", bonus_hit, score_p0, hole_mask, target_valid);
      end
      wait_valid("collision");
   endtask

   task automatic test_exhaustion;
      int r0;
      new_round_pulse(3'd0);
      for (int i = 0; i < 6; i++) begin
         wait_valid("exhaust");
         checks++;
         if (target_hole !== 3'(i)) begin
            errors++;
            $display("FAIL exhaust_seq: th=%0d, required %0d", target_hole, i);
         end
         do_hit(3'(i), 1'b0, 3'd0);
      end
      sc0 = 50;
      r0 = rise_cnt;
      repeat (20) @(negedge clk);
      checks++;
      if (target_valid !== 1'b0 || rand_rise !== 1'b0 || hole_mask !== 6'b111111 || target_hole !== 3'd5) begin
         errors++;
         $display("FAIL exhausted: tv=%b rr=%b mask=%b th=%0d, required 0 0 111111 5", target_valid, rand_rise, hole_mask, target_hole);
      end
      checks++;
      if (rise_cnt != r0 + 1 || score_p0 !== 8'd50) begin
         errors++;
         $display("FAIL exhaust_quiet: rises=%0d p0=%0d, required %0d 50", rise_cnt, score_p0, r0 + 1);
      end
      new_round_pulse(3'd0);
      checks++;
      if (hole_mask !== 6'b000000 || score_p0 !== 8'd50 || score_p1 !== 8'd5) begin
         errors++;
         $display("FAIL exhaust_newround: mask=%b p0=%0d p1=%0d, required 000000 50 5", hole_mask, score_p0, score_p1);
      end
      wait_valid("exhaust_new");
   endtask

   task automatic test_saturation;
      for (int k = 0; k < 51; k++) begin
         new_round_pulse(3'd0);
         wait_valid("sat_a");
         do_hit(3'd0, 1'b1, 3'd0);
         sc1 = (sc1 + 5 > 255) ? 255 : sc1 + 5;
         checks++;
         if (score_p1 !== 8'(sc1)) begin
            errors++;
            $display("FAIL sat_step%0d: p1=%0d, required %0d", k, score_p1, sc1);
         end
         wait_valid("sat_b");
      end
      checks++;
      if (score_p1 !== 8'd255 || score_p0 !== 8'd50) begin
         errors++;
         $display("FAIL sat_final: p1=%0d p0=%0d, required 255 50", score_p1, score_p0);
      end
   endtask

   task automatic test_reset_mid;
      ball_in_hole = 1'b1; ball_hole = 3'd1; player = 1'b0;
      #2 resetN = 1'b0;
      #1;
      checks++;
      if ({target_hole, target_valid, hole_mask, bonus_hit, rand_rise} !== 12'd0 ||
          {score_p0, score_p1, frames_left} !== 25'd0) begin
         errors++;
         $display("FAIL reset_mid: th=%0d tv=%b mask=%b p0=%0d p1=%0d fl=%0d, required all 0", target_hole, target_valid, hole_mask, score_p0, score_p1, frames_left);
      end
      @(negedge clk);
      ball_in_hole = 1'b0;
      resetN = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (target_valid !== 1'b0 || rand_rise !== 1'b0 || score_p0 !== 8'd0 || hole_mask !== 6'd0) begin
         errors++;
         $display("FAIL reset_idle: tv=%b rr=%b p0=%0d mask=%b, required 0 0 0 000000", target_valid, rand_rise, score_p0, hole_mask);
      end
      new_round_pulse(3'd2);
      wait_valid("after_reset");
      checks++;
      if (target_hole !== 3'd2 || score_p0 !== 8'd0 || score_p1 !== 8'd0) begin
         errors++;
         $display("FAIL reset_restart: th=%0d p0=%0d p1=%0d, required 2 0 0", target_hole, score_p0, score_p1);
      end
   endtask

   initial begin
      test_reset;
      test_basic_target;
      test_hit_scoring;
      test_non_target;
      test_probe_wrap;
      test_timeout;
      test_exhaustion;
      test_saturation;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
